// File: rtl/circuit_sweep_if.sv
// Stimulus/response bundle between the sweep controller and its requester.
// The requester (master) starts runs and returns the circuit response; the sweeper (slave) drives vectors.
interface circuit_sweep_if;
   logic       start;
   logic       mode;
   logic [4:0] seed;
   logic [4:0] vec_out;
   logic       vec_valid;
   logic [4:0] resp_in;
   logic       busy;
   logic       done;
   logic [5:0] count;
   logic [4:0] signature;

   modport master (
      output start, mode, seed, resp_in,
      input  vec_out, vec_valid, busy, done, count, signature
   );

   modport slave (
      input  start, mode, seed, resp_in,
      output vec_out, vec_valid, busy, done, count, signature
   );
endinterface

// File: rtl/circuit_sweep.sv
// Exhaustive/pseudo-random sweep of a 5-bit combinational circuit with MISR compaction of its
// responses, tolerating a fixed response latency of LAT cycles.
module circuit_sweep #(
   parameter int unsigned NUM_VEC = 32,
   parameter int unsigned LAT     = 0
) (
   input logic            clk,
   input logic            rst_n,
   circuit_sweep_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StDrive, StDrain, StDone} state_e;

   localparam logic [4:0] LastCnt  = 5'(NUM_VEC - 1);
   localparam logic [4:0] LastLfsr = 5'd30;
   localparam logic [3:0] TapMask  = 4'((1 << (LAT + 1)) - 1);

   state_e     state_q;
   logic       mode_q;
   logic [4:0] vec_q;
   logic [4:0] idx_q;
   logic       valid_q;
   logic       busy_q;
   logic       done_q;
   logic [5:0] count_q;
   logic [4:0] sig_q;
   logic [2:0] pipe_q;

   logic [3:0] taps;
   logic       cmp_en;
   logic       pending;
   logic       last_vec;

   function automatic logic [4:0] misr_step(input logic [4:0] s, input logic [4:0] r);
      misr_step = {s[3], s[2], s[1] ^ s[4], s[0], s[4]} ^ r;
   endfunction

   // taps[i] is the valid flag of the vector issued i cycles ago.
   assign taps     = {pipe_q, valid_q};
   assign cmp_en   = taps[LAT[1:0]];
   assign pending  = |(taps & TapMask);
   assign last_vec = mode_q ? (idx_q == LastLfsr) : (idx_q == LastCnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         mode_q  <= 1'b0;
         vec_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         count_q <= '0;
         sig_q   <= '0;
         pipe_q  <= '0;
      end else begin
         pipe_q <= {pipe_q[1:0], valid_q};
         if (cmp_en) begin
            sig_q <= misr_step(sig_q, bus.resp_in);
            if (count_q != 6'd32) count_q <= count_q + 6'd1;
         end
         unique case (state_q)
            StIdle, StDone: begin
               if (bus.start) begin
                  state_q <= StDrive;
                  mode_q  <= bus.mode;
                  vec_q   <= bus.mode ? ((bus.seed == 5'd0) ? 5'd1 : bus.seed) : 5'd0;
                  idx_q   <= '0;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  count_q <= '0;
                  sig_q   <= '0;
               end
            end
            StDrive: begin
               if (last_vec) begin
                  state_q <= StDrain;
                  valid_q <= 1'b0;
               end else begin
                  idx_q <= idx_q + 5'd1;
                  vec_q <= mode_q ? {vec_q[3:0], vec_q[4] ^ vec_q[2]} : vec_q + 5'd1;
               end
            end
            StDrain: begin
               // Leave once no issued vector is still waiting for its response.
               if (!pending) begin
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.vec_out   = vec_q;
   assign bus.vec_valid = valid_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.count     = count_q;
   assign bus.signature = sig_q;

endmodule

// File: tb/tb_circuit_sweep.sv
// Bench for circuit_sweep: three instances (32/0, 2/0, 32/3) run in lockstep against a
// run-offset model of the expected outputs, plus directed literal checks.
module tb_circuit_sweep;

   localparam int NV [3] = '{32, 2, 32};
   localparam int LT [3] = '{0, 0, 3};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic mode = 1'b0;
   logic [4:0] seed = 5'd0;
   int circ = 0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   circuit_sweep_if bus0 ();
   circuit_sweep_if bus1 ();
   circuit_sweep_if bus2 ();

   circuit_sweep #(.NUM_VEC(32), .LAT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   circuit_sweep #(.NUM_VEC(2), .LAT(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   circuit_sweep #(.NUM_VEC(32), .LAT(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   // Downstream circuit under test, selectable per run.
   function automatic logic [4:0] resp_f(input int c, input logic [4:0] v);
      case (c)
         0: resp_f = 5'd0;
         1: resp_f = 5'd1;
         default: resp_f = v ^ {v[2:0], v[4:3]} ^ 5'b10110;
      endcase
   endfunction

   logic [4:0] rp0, rp1, rp2;
   always @(posedge clk) begin
      rp0 <= resp_f(circ, bus2.vec_out);
      rp1 <= rp0;
      rp2 <= rp1;
   end

   assign bus0.start = start; assign bus0.mode = mode; assign bus0.seed = seed;
   assign bus1.start = start; assign bus1.mode = mode; assign bus1.seed = seed;
   assign bus2.start = start; assign bus2.mode = mode; assign bus2.seed = seed;
   assign bus0.resp_in = resp_f(circ, bus0.vec_out);
   assign bus1.resp_in = resp_f(circ, bus1.vec_out);
   assign bus2.resp_in = rp2;

   logic [4:0] vo [3];
   logic       vv [3];
   logic       bz [3];
   logic       dn [3];
   logic [5:0] ct [3];
   logic [4:0] sg [3];
   assign vo[0] = bus0.vec_out;   assign vo[1] = bus1.vec_out;   assign vo[2] = bus2.vec_out;
   assign vv[0] = bus0.vec_valid; assign vv[1] = bus1.vec_valid; assign vv[2] = bus2.vec_valid;
   assign bz[0] = bus0.busy;      assign bz[1] = bus1.busy;      assign bz[2] = bus2.busy;
   assign dn[0] = bus0.done;      assign dn[1] = bus1.done;      assign dn[2] = bus2.done;
   assign ct[0] = bus0.count;     assign ct[1] = bus1.count;     assign ct[2] = bus2.count;
   assign sg[0] = bus0.signature; assign sg[1] = bus1.signature; assign sg[2] = bus2.signature;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- model ----------------
   // i-th vector of a run, straight from the sequence definition.
   function automatic logic [4:0] seqv(input bit m, input logic [4:0] sd, input int i);
      logic [4:0] v;
      if (!m) return 5'(i);
      v = (sd == 5'd0) ? 5'd1 : sd;
      for (int j = 0; j < i; j++) v = {v[3:0], v[4] ^ v[2]};
      return v;
   endfunction

   function automatic logic [4:0] misr_m(input logic [4:0] s, input logic [4:0] r);
      logic [4:0] n;
      n = {s[3:0], s[4]};
      n[2] = n[2] ^ s[4];
      return n ^ r;
   endfunction

   function automatic logic [4:0] fold(input bit m, input logic [4:0] sd, input int c,
                                       input int n);
      logic [4:0] s = 5'd0;
      for (int j = 0; j < n; j++) s = misr_m(s, resp_f(c, seqv(m, sd, j)));
      return s;
   endfunction

   // k = cycle offset since the accepted start (1 = first vector cycle), -1 = idle since reset.
   int         k  [3] = '{-1, -1, -1};
   bit         mm [3];
   logic [4:0] ms [3];
   int         mc [3];

   function automatic int run_len(input int d);
      return mm[d] ? 31 : NV[d];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int d = 0; d < 3; d++) begin
         if (!rst_n) k[d] = -1;
         else if (start && (k[d] < 0 || k[d] > run_len(d) + LT[d] + 1)) begin
            k[d] = 1; mm[d] = mode; ms[d] = seed; mc[d] = circ;
         end else if (k[d] >= 1 && k[d] < 1000) k[d] = k[d] + 1;
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         int r, l, kk, c;
         logic [4:0] ev, es;
         logic ea, eb, ed;
         r = run_len(d); l = LT[d]; kk = k[d];
         if (kk < 0) begin
            ev = 0; ea = 0; eb = 0; ed = 0; c = 0; es = 0;
         end else begin
            ea = (kk <= r);
            ev = seqv(mm[d], ms[d], (kk <= r) ? kk - 1 : r - 1);
            eb = (kk <= r + l + 1);
            ed = !eb;
            c = kk - 1 - l;
            if (c < 0) c = 0;
            if (c > r) c = r;
            es = fold(mm[d], ms[d], mc[d], c);
         end
         chk($sformatf("dut%0d.vec_out k=%0d", d, kk), 32'(vo[d]), 32'(ev));
         chk($sformatf("dut%0d.vec_valid k=%0d", d, kk), 32'(vv[d]), 32'(ea));
         chk($sformatf("dut%0d.busy k=%0d", d, kk), 32'(bz[d]), 32'(eb));
         chk($sformatf("dut%0d.done k=%0d", d, kk), 32'(dn[d]), 32'(ed));
         chk($sformatf("dut%0d.count k=%0d", d, kk), 32'(ct[d]), 32'(c));
         chk($sformatf("dut%0d.signature k=%0d", d, kk), 32'(sg[d]), 32'(es));
      end
   end

   // Recorder for directed checks.
   logic [4:0] rec_q[$];
   int busy_cnt [3];
   always @(negedge clk) begin
      if (bus0.vec_valid) rec_q.push_back(bus0.vec_out);
      for (int d = 0; d < 3; d++) if (bz[d]) busy_cnt[d]++;
   end

   task automatic clear_rec();
      rec_q.delete();
      for (int d = 0; d < 3; d++) busy_cnt[d] = 0;
   endtask

   task automatic pulse_start(input bit m, input logic [4:0] sd, input int c);
      @(posedge clk); #1;
      clear_rec();
      circ = c; mode = m; seed = sd; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_all_done();
      bit ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         ok = dn[0] && dn[1] && dn[2];
      end
      if (!ok) begin
         n_cmp++; n_err++;
         $display("FAIL wait_all_done: done never reached within 300 cycles");
      end
   endtask

   initial begin
      int dups;
      repeat (3) @(posedge clk);
      #1;
      chk("reset.count", 32'(bus0.count), 0);
      chk("reset.signature", 32'(bus2.signature), 0);
      rst_n = 1'b1;

      // Run A: counting sweep, zero response.
      pulse_start(1'b0, 5'd0, 0);
      wait_all_done();
      chk("A.dut0.count", 32'(bus0.count), 32);
      chk("A.dut0.signature", 32'(bus0.signature), 0);
      chk("A.valid_cycles", 32'(rec_q.size()), 32);
      for (int i = 0; i < 32 && i < rec_q.size(); i++) chk($sformatf("A.vec[%0d]", i),
                                                           32'(rec_q[i]), i);

      // Run B: started in the first done cycle, response tied to 1.
      clear_rec();
      circ = 1; mode = 1'b0; seed = 5'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      // Start in dut1's last drain cycle must be ignored.
      @(posedge clk); @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_all_done();
      chk("B.dut1.signature", 32'(bus1.signature), 32'h03);
      chk("B.dut1.count", 32'(bus1.count), 2);

      // Run C: LFSR from seed 1, nontrivial circuit.
      pulse_start(1'b1, 5'd1, 2);
      wait_all_done();
      chk("C.vec0", 32'(rec_q[0]), 32'h01);
      chk("C.vec1", 32'(rec_q[1]), 32'h02);
      chk("C.vec2", 32'(rec_q[2]), 32'h04);
      chk("C.vec3", 32'(rec_q[3]), 32'h09);
      chk("C.valid_cycles", 32'(rec_q.size()), 31);
      dups = 0;
      for (int i = 0; i < rec_q.size(); i++)
         for (int j = i + 1; j < rec_q.size(); j++) if (rec_q[i] == rec_q[j]) dups++;
      chk("C.repeats", 32'(dups), 0);
      chk("C.drain_extra", 32'(busy_cnt[2] - busy_cnt[0]), 3);
      chk("C.lat3_vs_lat0_sig", 32'(bus2.signature), 32'(bus0.signature));

      // Run D: seed 0, with a stray start during DRIVE.
      pulse_start(1'b1, 5'd0, 2);
      mode = 1'b0; seed = 5'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_all_done();
      chk("D.vec0", 32'(rec_q[0]), 32'h01);
      chk("D.valid_cycles", 32'(rec_q.size()), 31);

      // Run E: reset at vector 10, then a clean rerun.
      pulse_start(1'b0, 5'd0, 2);
      begin
         bit hit = 0;
         for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            hit = bus0.vec_valid && (bus0.vec_out == 5'd10);
         end
         if (!hit) begin
            n_cmp++; n_err++;
            $display("FAIL E.wait_vec10: vector 10 never seen");
         end
      end
      #1 rst_n = 1'b0;
      #1;
      chk("E.rst.vec_out", 32'(bus0.vec_out), 0);
      chk("E.rst.vec_valid", 32'(bus0.vec_valid), 0);
      chk("E.rst.busy", 32'(bus2.busy), 0);
      chk("E.rst.done", 32'(bus1.done), 0);
      chk("E.rst.count", 32'(bus2.count), 0);
      chk("E.rst.signature", 32'(bus0.signature), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      pulse_start(1'b0, 5'd0, 2);
      wait_all_done();
      chk("E.rerun.count", 32'(bus0.count), 32);
      chk("E.rerun.signature", 32'(bus2.signature), 32'(fold(1'b0, 5'd0, 2, 32)));
      repeat (3) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
